la_arbiter8: RTL and testbench

Round-robin arbiter that produces registered one-hot select lines for an 8-input one-hot mux such as `la_dmux8`. It shares one downstream sink among 8 requesters. A grant is held for a multi-beat transfer until the granted requester marks its last beat, withdraws its request, or reaches a beat limit. Grant handover is zero-bubble, and the arbiter guarantees starvation-free rotation. It sits directly in front of the mux: `grant[i]` drives `sel<i>`.

---
 rtl/la_arbiter8.sv | 117 +++++++++++
 tb/tb_la_arbiter8.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/la_arbiter8.sv
// Round-robin grant for an 8:1 one-hot mux, held across multi-beat transfers; grant/active registered, fire combinational.
// A release (last beat, abandon or beat limit) re-arbitrates in the same cycle, so handover has no bubble.
module la_arbiter8 #(
  parameter PROP = "DEFAULT",
  parameter int MAXBEATS = 16
) (
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic [7:0] req_i,
  input  logic [7:0] last_i,
  input  logic       ready_i,
  output logic [7:0] grant_o,
  output logic       active_o,
  output logic       fire_o
);

  localparam int CW = (MAXBEATS < 1) ? 1 : $clog2(MAXBEATS + 1);
  localparam logic [CW-1:0] CNT_LAST = (MAXBEATS < 1) ? '0 : CW'(MAXBEATS - 1);

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_e;

  state_e        state_q, state_d;
  logic [7:0]    grant_q, grant_d;
  logic [2:0]    ptr_q, ptr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          active_q, active_d;

  logic [2:0]    g_idx;
  logic          g_req, g_last, fire, at_limit, rel;

  // First requester at or after p, wrapping modulo 8.
  function automatic logic [7:0] rr_pick(input logic [7:0] r, input logic [2:0] p);
    logic [7:0] w;
    logic       hit;
    logic [2:0] idx;
    w   = '0;
    hit = 1'b0;
    for (int k = 0; k < 8; k++) begin
      idx = p + 3'(k);
      if (!hit && r[idx]) begin
        w[idx] = 1'b1;
        hit    = 1'b1;
      end
    end
    return w;
  endfunction

  always_comb begin
    g_idx = '0;
    for (int i = 0; i < 8; i++) begin
      if (grant_q[i]) g_idx = 3'(i);
    end
  end

  assign g_req    = |(grant_q & req_i);
  assign g_last   = |(grant_q & last_i);
  assign fire     = g_req & ready_i;
  assign at_limit = (MAXBEATS != 0) && (cnt_q == CNT_LAST);
  // Dropping req on the granted line is an abandon even if ready is high that cycle.
  assign rel      = (state_q == BUSY) && ((fire && g_last) || !g_req || (fire && at_limit));

  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    ptr_d    = ptr_q;
    cnt_d    = cnt_q;
    case (state_q)
      IDLE: begin
        if (|req_i) begin
          grant_d = rr_pick(req_i, ptr_q);
          cnt_d   = '0;
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (rel) begin
          ptr_d   = g_idx + 3'd1;
          grant_d = rr_pick(req_i & ~grant_q, g_idx + 3'd1);
          cnt_d   = '0;
          state_d = (|(req_i & ~grant_q)) ? BUSY : IDLE;
        end else if (fire && (MAXBEATS != 0)) begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: begin
        state_d = IDLE;
        grant_d = '0;
        cnt_d   = '0;
      end
    endcase
    active_d = |grant_d;
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q  <= IDLE;
      grant_q  <= '0;
      ptr_q    <= '0;
      cnt_q    <= '0;
      active_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      ptr_q    <= ptr_d;
      cnt_q    <= cnt_d;
      active_q <= active_d;
    end
  end

  assign grant_o  = grant_q;
  assign active_o = active_q;
  assign fire_o   = fire;

endmodule

// File: tb/tb_la_arbiter8.sv
// Bench for la_arbiter8 (MAXBEATS=4): directed scenarios then random traffic, checked against an index-level model.
module tb_la_arbiter8;

  localparam int MB = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] req = '0;
  logic [7:0] last = '0;
  logic       ready = 1'b0;
  logic [7:0] grant;
  logic       active;
  logic       fire;

  int n_checks = 0;
  int n_errors = 0;

  // Reference state: owner index (-1 when nobody holds the sink), rotation start, beats done by owner.
  int m_owner = -1;
  int m_ptr   = 0;
  int m_beats = 0;

  logic [7:0] cur_req;
  logic [7:0] rl;
  logic       rr;

  la_arbiter8 #(.PROP("DEFAULT"), .MAXBEATS(MB)) dut (
    .clk_i   (clk),
    .reset_i (reset),
    .req_i   (req),
    .last_i  (last),
    .ready_i (ready),
    .grant_o (grant),
    .active_o(active),
    .fire_o  (fire)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=%02h expected=%02h", tag, got, exp);
    end
  endtask

  function automatic int pick(input logic [7:0] m, input int start);
    for (int k = 0; k < 8; k++) begin
      if (m[(start + k) % 8]) return (start + k) % 8;
    end
    return -1;
  endfunction

  function automatic logic [7:0] exp_grant();
    logic [7:0] e;
    e = '0;
    if (m_owner >= 0) e[m_owner] = 1'b1;
    return e;
  endfunction

  task automatic model_advance(input logic [7:0] r, input logic [7:0] l, input logic rd);
    logic       f;
    logic       done;
    logic [7:0] others;
    if (m_owner < 0) begin
      if (r != 8'h00) begin
        m_owner = pick(r, m_ptr);
        m_beats = 0;
      end
    end else begin
      f    = r[m_owner] && rd;
      done = (f && l[m_owner]) || !r[m_owner] || (MB != 0 && f && (m_beats + 1 == MB));
      if (done) begin
        others          = r;
        others[m_owner] = 1'b0;
        m_ptr           = (m_owner + 1) % 8;
        m_owner         = pick(others, m_ptr);
        m_beats         = 0;
      end else if (f) begin
        m_beats++;
      end
    end
  endtask

  task automatic step(input logic [7:0] r, input logic [7:0] l, input logic rd);
    logic [7:0] e_act;
    logic [7:0] e_fire;
    @(negedge clk);
    req   = r;
    last  = l;
    ready = rd;
    #1;
    e_act  = (m_owner >= 0) ? 8'h01 : 8'h00;
    e_fire = (m_owner >= 0 && r[m_owner] && rd) ? 8'h01 : 8'h00;
    chk("grant", grant, exp_grant());
    chk("active", {7'b0, active}, e_act);
    chk("fire", {7'b0, fire}, e_fire);
    model_advance(r, l, rd);
  endtask

  // Asserts reset mid low-phase and checks the clear happens before any clock edge.
  task automatic do_reset();
    @(negedge clk);
    #2;
    reset = 1'b1;
    #1;
    chk("rst_grant", grant, 8'h00);
    chk("rst_active", {7'b0, active}, 8'h00);
    chk("rst_fire", {7'b0, fire}, 8'h00);
    m_owner = -1;
    m_ptr   = 0;
    m_beats = 0;
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    // Reset held from time zero, then a mid-transfer reset with all requests high.
    #1;
    chk("por_grant", grant, 8'h00);
    chk("por_active", {7'b0, active}, 8'h00);
    @(posedge clk);
    #1;
    reset = 1'b0;
    step(8'hFF, 8'h00, 1'b0);
    step(8'hFF, 8'h00, 1'b0);
    step(8'hFF, 8'h00, 1'b0);
    do_reset();
    step(8'hFF, 8'h00, 1'b0);
    step(8'hFF, 8'h00, 1'b0);

    // Single-beat rotation through every requester.
    do_reset();
    for (int n = 0; n < 11; n++) step(8'hFF, 8'hFF, 1'b1);

    // Multi-beat hold on index 0 with ready stalls, last on the third beat.
    do_reset();
    step(8'h05, 8'h00, 1'b0);
    step(8'h05, 8'h00, 1'b1);
    step(8'h05, 8'h00, 1'b0);
    step(8'h05, 8'h00, 1'b1);
    step(8'h05, 8'h01, 1'b1);
    step(8'h05, 8'h00, 1'b0);
    step(8'h05, 8'h00, 1'b0);

    // Abandon: granted index 1 drops its request while stalled.
    do_reset();
    step(8'h0A, 8'h00, 1'b0);
    step(8'h0A, 8'h00, 1'b0);
    step(8'h08, 8'h00, 1'b0);
    step(8'h08, 8'h00, 1'b0);
    step(8'h00, 8'h00, 1'b1);
    step(8'h00, 8'h00, 1'b1);

    // Beat limit alternating two streaming requesters.
    do_reset();
    for (int n = 0; n < 12; n++) step(8'h11, 8'h00, 1'b1);

    // Wrap: release index 6 leaves ptr at 7, then index 0 wins and hands over to 6.
    do_reset();
    step(8'h40, 8'h40, 1'b1);
    step(8'h40, 8'h40, 1'b1);
    step(8'h41, 8'h00, 1'b0);
    step(8'h41, 8'h00, 1'b0);
    step(8'h41, 8'h01, 1'b1);
    step(8'h41, 8'h00, 1'b0);
    step(8'h41, 8'h00, 1'b0);

    // Random traffic with sticky requests and occasional resets.
    do_reset();
    cur_req = 8'h00;
    for (int n = 0; n < 500; n++) begin
      for (int b = 0; b < 8; b++) begin
        if ($urandom_range(0, 5) == 0) cur_req[b] = ~cur_req[b];
      end
      rl = 8'($urandom) & 8'($urandom) & 8'($urandom);
      rr = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 149) == 0) do_reset();
      step(cur_req, rl, rr);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
